// File: rtl/piece_position_driver.sv
// -----------------------------------------------------------------------------
// piece_position_driver
//
// Holds the falling piece's anchor position in grid units (col, row) and
// drives the matching playfield pixel coordinates:
//     sq2 = 240 + 20*col      sq0 = 60 + 20*row
// The pixel coordinates are kept in their own registers and stepped by +/-20
// alongside the grid counters, so no multiplier is needed.
// Executes left/right/soft-down commands, gravity steps and hard drops, and
// pulses `landed` for one cycle when the piece locks.
//
// Parameters
//   GRAVITY_DIV  clock cycles between gravity steps (>= 2)
//   SPAWN_COL    spawn column, 0..9
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-high reset
//   spawn          start a new piece at (SPAWN_COL, 0); honoured only in IDLE
//   cmd_valid      command request
//   cmd[1:0]       00 left, 01 right, 10 soft down, 11 hard drop
//   cmd_ready      command accepted when cmd_valid & cmd_ready
//   blocked_left   collision flags for the current registered position
//   blocked_right
//   blocked_down
//   col[3:0]       current column, 0..9
//   row[4:0]       current row, 0..19
//   sq2[9:0]       pixel x of the anchor
//   sq0[9:0]       pixel y of the anchor
//   active         a piece is in play
//   landed         one-cycle pulse in the lock cycle
// -----------------------------------------------------------------------------
module piece_position_driver #(
    parameter int GRAVITY_DIV = 25_000_000,
    parameter int SPAWN_COL   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spawn,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    input  logic       blocked_left,
    input  logic       blocked_right,
    input  logic       blocked_down,
    output logic [3:0] col,
    output logic [4:0] row,
    output logic [9:0] sq2,
    output logic [9:0] sq0,
    output logic       active,
    output logic       landed
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DROP,
        S_LAND
    } state_e;

    localparam logic [1:0] CMD_LEFT  = 2'b00;
    localparam logic [1:0] CMD_RIGHT = 2'b01;
    localparam logic [1:0] CMD_DOWN  = 2'b10;
    localparam logic [1:0] CMD_HARD  = 2'b11;

    localparam logic [3:0] COL_MAX = 4'd9;
    localparam logic [4:0] ROW_MAX = 5'd19;
    localparam logic [9:0] STEP    = 10'd20;
    localparam logic [9:0] X0      = 10'd240;
    localparam logic [9:0] Y0      = 10'd60;
    // Elaboration-time constant; no runtime multiply.
    localparam logic [9:0] SPAWN_X = 10'(240 + 20 * SPAWN_COL);

    localparam int              CNT_W   = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GRAVITY_DIV - 1);

    state_e           state, state_n;
    logic [3:0]       col_n;
    logic [4:0]       row_n;
    logic [9:0]       sq2_n, sq0_n;
    logic [CNT_W-1:0] gcnt, gcnt_n;
    logic             pend, pend_n;

    logic tick;       // gravity counter wraps this cycle
    logic accept;     // command handshake this cycle
    logic floor_hit;  // a downward step from here would lock the piece
    logic do_down;    // one soft-down step (command, tick, pending tick or drop)

    assign tick      = (state == S_ACTIVE) && (gcnt == CNT_MAX);
    assign cmd_ready = (state == S_ACTIVE) && !pend;
    assign accept    = cmd_valid && cmd_ready;
    assign floor_hit = (row == ROW_MAX) || blocked_down;

    // The piece stays "in play" through the lock cycle; active drops on the
    // edge that returns to IDLE.
    assign active = (state != S_IDLE);
    assign landed = (state == S_LAND);

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave it unassigned and infer a latch.
        state_n = state;
        col_n   = col;
        row_n   = row;
        sq2_n   = sq2;
        sq0_n   = sq0;
        gcnt_n  = gcnt;
        pend_n  = pend;
        do_down = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (spawn) begin
                    state_n = S_ACTIVE;
                    col_n   = 4'(SPAWN_COL);
                    row_n   = '0;
                    sq2_n   = SPAWN_X;
                    sq0_n   = Y0;
                    gcnt_n  = '0;
                    pend_n  = 1'b0;
                end
            end

            S_ACTIVE: begin
                gcnt_n = tick ? '0 : gcnt + CNT_W'(1);

                if (pend) begin
                    // Deferred gravity step; cmd_ready is low so no command
                    // competes with it. The counter already wrapped when the
                    // tick fired, so the gravity period stays regular.
                    pend_n  = 1'b0;
                    do_down = 1'b1;
                end else if (accept) begin
                    unique case (cmd)
                        CMD_LEFT: begin
                            if (col != 4'd0 && !blocked_left) begin
                                col_n = col - 4'd1;
                                sq2_n = sq2 - STEP;
                            end
                            pend_n = tick;
                        end
                        CMD_RIGHT: begin
                            if (col != COL_MAX && !blocked_right) begin
                                col_n = col + 4'd1;
                                sq2_n = sq2 + STEP;
                            end
                            pend_n = tick;
                        end
                        CMD_DOWN: begin
                            // A manual step restarts the gravity interval, so
                            // a coincident tick is simply dropped.
                            gcnt_n  = '0;
                            do_down = 1'b1;
                        end
                        CMD_HARD: begin
                            state_n = S_DROP;
                        end
                        default: ;
                    endcase
                end else if (tick) begin
                    do_down = 1'b1;
                end
            end

            S_DROP: begin
                do_down = 1'b1;
            end

            S_LAND: begin
                state_n = S_IDLE;
            end

            default: state_n = S_IDLE;
        endcase

        if (do_down) begin
            if (floor_hit) begin
                state_n = S_LAND;
            end else begin
                row_n = row + 5'd1;
                sq0_n = sq0 + STEP;
            end
        end

        // Gravity only runs in ACTIVE; leaving it discards any pending tick.
        if (state_n != S_ACTIVE) begin
            gcnt_n = '0;
            pend_n = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State and position registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            col   <= '0;
            row   <= '0;
            sq2   <= X0;
            sq0   <= Y0;
            gcnt  <= '0;
            pend  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples
            // the values computed from the previous cycle's state.
            state <= state_n;
            col   <= col_n;
            row   <= row_n;
            sq2   <= sq2_n;
            sq0   <= sq0_n;
            gcnt  <= gcnt_n;
            pend  <= pend_n;
        end
    end

endmodule

// File: tb/tb_piece_position_driver.sv
// -----------------------------------------------------------------------------
// tb_piece_position_driver
//
// Directed bench for piece_position_driver with GRAVITY_DIV = 4 and
// SPAWN_COL = 4. A table of per-cycle vectors covers spawning, moves at the
// wall, blocked moves, a command coinciding with a gravity tick, plain
// gravity and a soft down that restarts the gravity interval. Hand-written
// sequences cover hard drops to the floor and onto an obstruction, and an
// asynchronous reset in the middle of a drop.
// -----------------------------------------------------------------------------
module tb_piece_position_driver;

    localparam int GDIV = 4;

    logic       clk;
    logic       rst;
    logic       spawn;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       cmd_ready;
    logic       blocked_left;
    logic       blocked_right;
    logic       blocked_down;
    logic [3:0] col;
    logic [4:0] row;
    logic [9:0] sq2;
    logic [9:0] sq0;
    logic       active;
    logic       landed;

    int n_cmp = 0;
    int n_bad = 0;

    piece_position_driver #(
        .GRAVITY_DIV (GDIV),
        .SPAWN_COL   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .spawn         (spawn),
        .cmd_valid     (cmd_valid),
        .cmd           (cmd),
        .cmd_ready     (cmd_ready),
        .blocked_left  (blocked_left),
        .blocked_right (blocked_right),
        .blocked_down  (blocked_down),
        .col           (col),
        .row           (row),
        .sq2           (sq2),
        .sq0           (sq0),
        .active        (active),
        .landed        (landed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sp;
        logic       vld;
        logic [1:0] c;
        logic       bl;
        logic       br;
        logic       bd;
        int         e_col;
        int         e_row;
        int         e_sq2;
        int         e_sq0;
        logic       e_act;
        logic       e_land;
        logic       e_rdy;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int e_col, input int e_row,
                             input int e_sq2, input int e_sq0, input logic e_act,
                             input logic e_land, input logic e_rdy);
        check({tag, ".col"},       16'(col),       16'(e_col));
        check({tag, ".row"},       16'(row),       16'(e_row));
        check({tag, ".sq2"},       16'(sq2),       16'(e_sq2));
        check({tag, ".sq0"},       16'(sq0),       16'(e_sq0));
        check({tag, ".active"},    16'(active),    16'(e_act));
        check({tag, ".landed"},    16'(landed),    16'(e_land));
        check({tag, ".cmd_ready"}, 16'(cmd_ready), 16'(e_rdy));
    endtask

    task automatic add(input logic sp, input logic vld, input logic [1:0] c,
                       input logic bl, input logic br, input logic bd,
                       input int e_col, input int e_row, input int e_sq2, input int e_sq0,
                       input logic e_act, input logic e_land, input logic e_rdy);
        vec_t v;
        v.sp = sp; v.vld = vld; v.c = c; v.bl = bl; v.br = br; v.bd = bd;
        v.e_col = e_col; v.e_row = e_row; v.e_sq2 = e_sq2; v.e_sq0 = e_sq0;
        v.e_act = e_act; v.e_land = e_land; v.e_rdy = e_rdy;
        vq.push_back(v);
    endtask

    // One clock edge, then settle past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        spawn         = 1'b0;
        cmd_valid     = 1'b0;
        cmd           = 2'b00;
        blocked_left  = 1'b0;
        blocked_right = 1'b0;
        blocked_down  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Command codes: 0 left, 1 right, 2 soft down, 3 hard drop.
        // Expected outputs are after the edge that consumes the inputs.
        //   sp vld c  bl br bd | col row sq2 sq0 act land rdy
        add(1, 0, 0, 0, 0, 0,   4, 0, 320,  60, 1, 0, 1); //  0 spawn
        add(0, 1, 0, 0, 0, 0,   3, 0, 300,  60, 1, 0, 1); //  1 left
        add(0, 1, 0, 0, 0, 0,   2, 0, 280,  60, 1, 0, 1); //  2 left
        add(0, 1, 0, 0, 0, 0,   1, 0, 260,  60, 1, 0, 1); //  3 left
        add(0, 1, 0, 0, 0, 0,   0, 0, 240,  60, 1, 0, 0); //  4 left + tick -> pending
        add(0, 1, 0, 0, 0, 0,   0, 1, 240,  80, 1, 0, 1); //  5 pending step, cmd ignored
        add(0, 1, 0, 0, 0, 0,   0, 1, 240,  80, 1, 0, 1); //  6 left at wall: no-op
        add(1, 1, 1, 0, 1, 0,   0, 1, 240,  80, 1, 0, 1); //  7 right blocked, spawn ignored
        add(0, 0, 0, 0, 0, 0,   0, 2, 240, 100, 1, 0, 1); //  8 gravity tick
        add(0, 0, 0, 0, 0, 0,   0, 2, 240, 100, 1, 0, 1); //  9
        add(0, 0, 0, 0, 0, 0,   0, 2, 240, 100, 1, 0, 1); // 10
        add(0, 1, 2, 0, 0, 0,   0, 3, 240, 120, 1, 0, 1); // 11 soft down, counter restarts
        add(0, 0, 0, 0, 0, 0,   0, 3, 240, 120, 1, 0, 1); // 12 old tick slot: no step
        add(0, 0, 0, 0, 0, 0,   0, 3, 240, 120, 1, 0, 1); // 13
        add(0, 0, 0, 0, 0, 0,   0, 3, 240, 120, 1, 0, 1); // 14
        add(0, 0, 0, 0, 0, 0,   0, 4, 240, 140, 1, 0, 1); // 15 tick 4 cycles after soft down
        add(0, 1, 1, 0, 0, 0,   1, 4, 260, 140, 1, 0, 1); // 16 right
        add(0, 1, 0, 1, 0, 0,   1, 4, 260, 140, 1, 0, 1); // 17 left blocked
        add(0, 1, 3, 0, 0, 0,   1, 4, 260, 140, 1, 0, 0); // 18 hard drop -> DROP

        // ---------------- reset ----------------
        idle_inputs();
        rst = 1'b1;
        #12;
        check_out("reset_async", 0, 0, 240, 60, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_out("reset_idle", 0, 0, 240, 60, 1'b0, 1'b0, 1'b0);

        // ---------------- table ----------------
        foreach (vq[i]) begin
            spawn         = vq[i].sp;
            cmd_valid     = vq[i].vld;
            cmd           = vq[i].c;
            blocked_left  = vq[i].bl;
            blocked_right = vq[i].br;
            blocked_down  = vq[i].bd;
            step();
            check_out($sformatf("vec%0d", i), vq[i].e_col, vq[i].e_row, vq[i].e_sq2,
                      vq[i].e_sq0, vq[i].e_act, vq[i].e_land, vq[i].e_rdy);
        end
        idle_inputs();

        // ---------------- hard drop from row 4 to the floor ----------------
        // Commands are held valid during the drop and must be ignored.
        cmd_valid = 1'b1;
        cmd       = 2'b00;
        for (int r = 5; r <= 19; r++) begin
            step();
            check_out($sformatf("drop_r%0d", r), 1, r, 260, 60 + 20 * r, 1'b1, 1'b0, 1'b0);
        end
        step();
        check("floor_land.landed", 16'(landed), 16'd1);
        check("floor_land.row",    16'(row),    16'd19);
        check("floor_land.sq0",    16'(sq0),    16'd440);
        cmd_valid = 1'b0;
        step();
        check_out("floor_idle", 1, 19, 260, 440, 1'b0, 1'b0, 1'b0);

        // ---------------- hard drop onto an obstruction at row 7 ----------------
        spawn = 1'b1;
        step();
        spawn = 1'b0;
        check_out("spawn2", 4, 0, 320, 60, 1'b1, 1'b0, 1'b1);
        cmd_valid = 1'b1;
        cmd       = 2'b11;
        step();
        cmd_valid = 1'b0;
        check_out("drop2_enter", 4, 0, 320, 60, 1'b1, 1'b0, 1'b0);
        for (int r = 1; r <= 7; r++) begin
            step();
            check_out($sformatf("drop2_r%0d", r), 4, r, 320, 60 + 20 * r, 1'b1, 1'b0, 1'b0);
        end
        blocked_down = 1'b1;
        step();
        blocked_down = 1'b0;
        check("block_land.landed", 16'(landed), 16'd1);
        check("block_land.row",    16'(row),    16'd7);
        check("block_land.sq0",    16'(sq0),    16'd200);
        step();
        check_out("block_idle", 4, 7, 320, 200, 1'b0, 1'b0, 1'b0);

        // ---------------- asynchronous reset during a drop at row 10 ----------------
        spawn = 1'b1;
        step();
        spawn     = 1'b0;
        cmd_valid = 1'b1;
        cmd       = 2'b11;
        step();
        cmd_valid = 1'b0;
        for (int r = 1; r <= 10; r++) step();
        check("rst_drop.row", 16'(row), 16'd10);
        #3;
        rst = 1'b1;
        #1;
        check_out("rst_mid_drop", 0, 0, 240, 60, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("rst_hold%0d.landed", k), 16'(landed), 16'd0);
        end
        #3;
        rst = 1'b0;
        step();
        check_out("rst_release", 0, 0, 240, 60, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
